// File: rtl/grf_scoreboard.sv
// Parametrised register file with a per-register saturating pending-write scoreboard for ID.
// Optional write-through forwarding is compiled in with `define GRF_BYPASS_EN.
module grf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int CNT_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr,
    output logic                    iss_ready,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    sb_err
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  cnt  [NREG];

    logic wr_live;
    logic iss_fire;
    logic wb_dec;
    logic wr_err;

    // Issue handshake: an issue is taken on the edge only when iss_en and
    // iss_ready are both high; otherwise ID holds iss_addr and retries.
    assign iss_ready = (iss_addr == '0) || (cnt[iss_addr] != CNT_MAX);
    assign iss_fire  = iss_en && iss_ready && (iss_addr != '0);
    assign wr_live   = wr_en && (wr_addr != '0);
    assign wb_dec    = wr_live && (cnt[wr_addr] != '0);
    assign wr_err    = wr_live && (cnt[wr_addr] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // An issue and a writeback on the same register cancel each other out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (iss_fire && (iss_addr == ADDR_W'(r)) &&
                    !(wb_dec && (wr_addr == ADDR_W'(r)))) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (wb_dec && (wr_addr == ADDR_W'(r)) &&
                             !(iss_fire && (iss_addr == ADDR_W'(r)))) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_err <= 1'b0;
        end else if (wr_err) begin
            sb_err <= 1'b1;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              pend;
        assign a    = rd_addr[g*ADDR_W +: ADDR_W];
        assign pend = (a != '0) && (cnt[a] != '0);
`ifdef GRF_BYPASS_EN
        logic hit;
        assign hit = wr_live && (wr_addr == a);
        assign rd_data[g*DATA_W +: DATA_W] = (a == '0) ? '0 : (hit ? wr_data : regs[a]);
        // The last outstanding write resolving this cycle is already forwarded.
        assign rd_busy[g] = pend && !(hit && wb_dec && (cnt[a] == CNT_ONE));
`else
        assign rd_data[g*DATA_W +: DATA_W] = (a == '0) ? '0 : regs[a];
        assign rd_busy[g] = pend;
`endif
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed self-checking bench for grf_scoreboard; expectations follow GRF_BYPASS_EN if defined.
module tb_grf_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        sb_err;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_q[$];

`ifdef GRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    grf_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then let reads settle.
    task automatic cyc(input logic ie, input logic [4:0] ia,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        iss_en   = ie;
        iss_addr = ia;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    logic [31:0] e;

    initial begin
        rst = 1'b0;
        rd_addr = '0;
        iss_en = 1'b0; iss_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #2;
        check("reset_rd_data", rd_data, 64'h0);
        check("reset_iss_ready", iss_ready, 1);
        check("reset_sb_err", sb_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            check($sformatf("post_reset_data_r%0d", i), rd_data, 64'h0);
            check($sformatf("post_reset_busy_r%0d", i), rd_busy, 2'b00);
        end
        check("post_reset_iss_ready", iss_ready, 1);
        check("post_reset_sb_err", sb_err, 0);

        // Write/forward on r5 (issued first so the write is expected)
        cyc(1'b1, 5'd5, 1'b0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd0);
        cyc(1'b0, 5'd0, 1'b1, 5'd5, 32'h1234_5678);
        check("r5_same_cycle", rd_data[31:0], BYP ? 32'h1234_5678 : 32'h0);
        check("r5_busy_same_cycle", rd_busy[0], BYP ? 1'b0 : 1'b1);
        idle();
        check("r5_next_cycle", rd_data[31:0], 32'h1234_5678);
        check("r5_busy_next_cycle", rd_busy[0], 1'b0);
        set_rd(5'd0, 5'd0);
        cyc(1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        check("r0_write_same", rd_data, 64'h0);
        idle();
        check("r0_write_next", rd_data, 64'h0);
        check("r0_write_no_err", sb_err, 0);

        // Saturating scoreboard on r8
        set_rd(5'd8, 5'd5);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 5'd8, 1'b0, 5'd0, 32'h0);
            check($sformatf("r8_iss_ready_%0d", k), iss_ready, 1);
        end
        cyc(1'b1, 5'd8, 1'b0, 5'd0, 32'h0);
        check("r8_full_iss_ready", iss_ready, 0);
        check("r8_full_busy", rd_busy, 2'b01);
        idle();
        check("r8_after_4th_busy", rd_busy[0], 1'b1);
        exp_q.push_back(32'hA000_0001);
        exp_q.push_back(32'hA000_0002);
        exp_q.push_back(32'hA000_0003);
        cyc(1'b0, 5'd0, 1'b1, 5'd8, 32'hA000_0001);
        check("r8_wb1_busy", rd_busy[0], 1'b1);
        cyc(1'b0, 5'd0, 1'b1, 5'd8, 32'hA000_0002);
        e = exp_q.pop_front();
        check("r8_wb1_data", rd_data[31:0], BYP ? 32'hA000_0002 : e);
        check("r8_wb2_busy", rd_busy[0], 1'b1);
        cyc(1'b0, 5'd0, 1'b1, 5'd8, 32'hA000_0003);
        e = exp_q.pop_front();
        check("r8_wb2_data", rd_data[31:0], BYP ? 32'hA000_0003 : e);
        check("r8_wb3_busy", rd_busy[0], BYP ? 1'b0 : 1'b1);
        cyc(1'b0, 5'd8, 1'b0, 5'd0, 32'h0);
        e = exp_q.pop_front();
        check("r8_wb3_data", rd_data[31:0], e);
        check("r8_cleared_busy", rd_busy[0], 1'b0);
        check("r8_iss_ready_again", iss_ready, 1);
        check("r8_no_err", sb_err, 0);

        // Simultaneous issue and writeback on r9
        set_rd(5'd9, 5'd9);
        cyc(1'b1, 5'd9, 1'b0, 5'd0, 32'h0);
        cyc(1'b1, 5'd9, 1'b1, 5'd9, 32'hCAFE_F00D);
        check("r9_sim_iss_ready", iss_ready, 1);
        check("r9_sim_busy", rd_busy, BYP ? 2'b00 : 2'b11);
        idle();
        check("r9_after_busy", rd_busy, 2'b11);
        check("r9_after_data", rd_data, 64'hCAFE_F00D_CAFE_F00D);
        check("r9_after_err", sb_err, 0);
        cyc(1'b0, 5'd0, 1'b1, 5'd9, 32'h0000_0099);
        idle();
        check("r9_final_busy", rd_busy, 2'b00);
        check("r9_final_data", rd_data[31:0], 32'h0000_0099);
        check("r9_final_err", sb_err, 0);

        // Unexpected write sets the sticky error
        set_rd(5'd7, 5'd8);
        cyc(1'b0, 5'd0, 1'b1, 5'd7, 32'h0000_0077);
        check("r7_err_before_edge", sb_err, 0);
        idle();
        check("r7_err_set", sb_err, 1);
        check("r7_data", rd_data[31:0], 32'h0000_0077);
        idle();
        check("r7_err_held", sb_err, 1);

        // Asynchronous reset mid-cycle with counters outstanding
        cyc(1'b1, 5'd10, 1'b0, 5'd0, 32'h0);
        cyc(1'b1, 5'd11, 1'b0, 5'd0, 32'h0);
        idle();
        set_rd(5'd10, 5'd11);
        check("pre_reset_busy", rd_busy, 2'b11);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_busy", rd_busy, 2'b00);
        check("async_err", sb_err, 0);
        set_rd(5'd7, 5'd8);
        check("async_data", rd_data, 64'h0);
        iss_addr = 5'd8;
        #1;
        check("async_iss_ready", iss_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 5'd0, 1'b1, 5'd10, 32'h1010_1010);
        idle();
        check("inflight_after_reset_err", sb_err, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/grf_scoreboard.md
# grf_scoreboard

Parametrised general register file with an integrated per-register pending-write scoreboard for the ID stage of the pipelined MIPS core. It generalises the fixed 32×32, two-read-port register file: width, register count and read-port count are parameters. It adds a saturating pending-write counter per register, so ID can stall on RAW hazards without a separate hazard unit. Reads are combinational; writes, issue marks and counters update on the rising clock edge.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, register index width; `2**ADDR_W` registers, register 0 hardwired to zero
- `NRD`, 2, number of read ports
- `CNT_W`, 2, pending-write counter width per register; maximum outstanding writes per register is `2**CNT_W-1`
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `rd_addr`  in  NRD*ADDR_W  read indices; port i at bits [i*ADDR_W +: ADDR_W]
- `rd_data`  out  NRD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
- `rd_busy`  out  NRD  port i's register has an outstanding write that is not being resolved this cycle
- `iss_en`  in  1  ID issues an instruction that will write `iss_addr`
- `iss_addr`  in  ADDR_W  destination register of the issued instruction
- `iss_ready`  out  1  `iss_addr`'s counter is below maximum; issue accepted only when high
- `wr_en`  in  1  WB write strobe
- `wr_addr`  in  ADDR_W  WB destination
- `wr_data`  in  DATA_W  WB data
- `sb_err`  out  1  sticky: a write arrived for a register with a zero counter

## Operation
- Storage: `2**ADDR_W` words of `DATA_W`, plus one `CNT_W` counter per register.
- Write: on the clock edge, if `wr_en` and `wr_addr != 0`, store `wr_data`. Writes to register 0 are dropped and leave its counter untouched.
- Read port i: if `rd_addr_i == 0`, output 0. Otherwise output the stored word, or the bypassed write value (see Configuration).
- Issue: `iss_fire = iss_en & iss_ready & (iss_addr != 0)`. `iss_ready = (iss_addr == 0) | (cnt[iss_addr] != max)`. `iss_en` while `iss_ready` is low is ignored; ID must hold and retry.
- Writeback decrement: `wb_dec = wr_en & (wr_addr != 0) & (cnt[wr_addr] != 0)`.
- Counter update per register r at the edge: +1 if only the issue targets r; −1 if only the decrement targets r; unchanged if both target r or neither does.
- Counters saturate by construction: increment is blocked at max via `iss_ready`; decrement is blocked at 0.
- Error: `wr_en & (wr_addr != 0) & (cnt[wr_addr] == 0)` sets `sb_err`. The data is still written, and `sb_err` stays set until reset.
- `rd_busy_i = (rd_addr_i != 0) & (cnt[rd_addr_i] != 0)`, reduced by the bypass rule when it is compiled in.

## Timing
- Reset (`rst` low, asynchronous): all registers 0, all counters 0, `sb_err` 0.
- Output values during and after reset: `rd_data` 0, `rd_busy` 0, `iss_ready` 1.
- Read latency is 0 cycles, combinational from `rd_addr` and state.
- A write at edge N is visible on `rd_data` from cycle N+1 without bypass, or already in cycle N with bypass.
- An issue at edge N makes `rd_busy` for that register high from cycle N+1.
- Reset asserted mid-operation clears all outstanding counts immediately. Any in-flight writes that arrive after reset release set `sb_err`; the pipeline must be flushed alongside.

## Configuration
- `GRF_BYPASS_EN` defined: write-through forwarding.
  - When `wr_en` is high, `wr_addr != 0` and `wr_addr == rd_addr_i`, port i outputs `wr_data` in the same cycle.
  - `rd_busy_i` is forced low when `cnt[rd_addr_i] == 1` and that same write is decrementing it.
- `GRF_BYPASS_EN` undefined: `rd_data` always comes from storage, and `rd_busy` reflects the registered counter only. ID stalls one extra cycle on a WB-to-ID hazard.

## Test plan
- Reset then read: release `rst`, read registers 0..31 on both ports → all data 0, `rd_busy` 0, `iss_ready` 1, `sb_err` 0.
- Write/forward: `wr_en` with r5 and 0x1234_5678, `rd_addr0` = 5 in the same cycle → 0x12345678 with bypass, old value 0 without. Both builds read 0x12345678 on the next cycle. Writing 0xFFFF_FFFF to r0 → r0 still reads 0.
- Scoreboard: issue r8 three times (CNT_W = 2) → `rd_busy` for r8 high. A fourth issue with `iss_en` high sees `iss_ready` 0 and the counter stays 3. Three writebacks → busy clears after the third; with bypass it is already low during the third write cycle.
- Simultaneous events: counter of r9 at 1, issue r9 and write r9 in the same cycle → counter stays 1, `rd_busy` stays high, data updated.
- Error and async reset: write r7 with a zero counter → `sb_err` 1 from the next cycle and held. Pull `rst` low mid-cycle with counters nonzero → `sb_err`, all counters and all data clear without waiting for a clock edge.
